// File: rtl/regfile_write_queue.sv
// In-order write queue in front of the register file: valid/ready intake, one drain per cycle,
// and a youngest-match lookup so readers can see writes that are still pending.
module regfile_write_queue #(
  parameter int W = 8,
  parameter int A = 3,
  parameter int D = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [A-1:0]           InAddr,
  input  logic [W-1:0]           InData,
  input  logic                   DrainEn,
  output logic                   WriteEn,
  output logic [A-1:0]           Waddr,
  output logic [W-1:0]           DataIn,
  input  logic [A-1:0]           LookupAddr,
  output logic                   LookupHit,
  output logic [W-1:0]           LookupData,
  output logic [$clog2(D+1)-1:0] Count,
  output logic                   Full,
  output logic                   Empty
);

  localparam int PW = $clog2(D);
  localparam int CW = $clog2(D + 1);

  logic [A-1:0]  r_addr [D];
  logic [W-1:0]  r_data [D];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [D-1:0]  w_match;
  logic [W-1:0]  w_match_data [D];

  assign w_full  = (r_count == CW'(D));
  assign w_empty = (r_count == '0);

  // Reset gates the handshakes directly so nothing moves while it is held low.
  assign InReady = Reset & ~w_full;
  assign WriteEn = Reset & ~w_empty & DrainEn;
  assign w_push  = InValid & InReady;
  assign w_pop   = WriteEn;

  assign Waddr  = w_empty ? '0 : r_addr[r_head];
  assign DataIn = w_empty ? '0 : r_data[r_head];
  assign Count  = r_count;
  assign Full   = w_full;
  assign Empty  = w_empty;

  // Slot gi holds the entry gi places younger than head; only resident entries may match.
  generate
    for (genvar gi = 0; gi < D; gi++) begin : g_match
      logic [PW-1:0] w_idx;
      assign w_idx             = r_head + PW'(gi);
      assign w_match[gi]      = (CW'(gi) < r_count) && (r_addr[w_idx] == LookupAddr);
      assign w_match_data[gi] = r_data[w_idx];
    end
  endgenerate

  always_comb begin
    LookupHit  = 1'b0;
    LookupData = '0;
    for (int k = 0; k < D; k++) begin
      if (w_match[k]) begin
        LookupHit  = 1'b1;
        LookupData = w_match_data[k];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < D; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_addr[r_tail] <= InAddr;
        r_data[r_tail] <= InData;
        r_tail         <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue: a vector table for the single-cycle behaviour and
// hand sequences with a push-order scoreboard for streaming and mid-operation reset.
module tb_regfile_write_queue;

  localparam int W = 8;
  localparam int A = 3;
  localparam int D = 4;
  localparam int CW = $clog2(D + 1);

  logic          Clk = 1'b0;
  logic          Reset;
  logic          InValid;
  logic          InReady;
  logic [A-1:0]  InAddr;
  logic [W-1:0]  InData;
  logic          DrainEn;
  logic          WriteEn;
  logic [A-1:0]  Waddr;
  logic [W-1:0]  DataIn;
  logic [A-1:0]  LookupAddr;
  logic          LookupHit;
  logic [W-1:0]  LookupData;
  logic [CW-1:0] Count;
  logic          Full;
  logic          Empty;

  regfile_write_queue #(.W(W), .A(A), .D(D)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady), .InAddr(InAddr),
    .InData(InData), .DrainEn(DrainEn), .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
    .LookupAddr(LookupAddr), .LookupHit(LookupHit), .LookupData(LookupData),
    .Count(Count), .Full(Full), .Empty(Empty)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic         rst;
    logic         v;
    logic [A-1:0] a;
    logic [W-1:0] d;
    logic         dr;
    logic [A-1:0] la;
    logic         e_rdy;
    logic         e_we;
    logic [A-1:0] e_wa;
    logic [W-1:0] e_wd;
    logic         e_hit;
    logic [W-1:0] e_ld;
    int           e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [A+W-1:0] sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic rst, input logic v, input int a, input int d, input logic dr,
                      input int la, input logic rdy, input logic we, input int wa, input int wd,
                      input logic hit, input int ld, input int cnt);
    vec_t t;
    t.rst = rst; t.v = v; t.a = A'(a); t.d = W'(d); t.dr = dr; t.la = A'(la);
    t.e_rdy = rdy; t.e_we = we; t.e_wa = A'(wa); t.e_wd = W'(wd);
    t.e_hit = hit; t.e_ld = W'(ld); t.e_cnt = cnt;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic rst, input logic v, input int a, input int d,
                       input logic dr, input int la);
    Reset = rst; InValid = v; InAddr = A'(a); InData = W'(d); DrainEn = dr; LookupAddr = A'(la);
  endtask

  // Inputs change 1ns after posedge; outputs are sampled on the falling edge.
  task automatic finish_cycle();
    @(posedge Clk);
    #1;
  endtask

  // Streaming cycle: scoreboard records accepted pushes and checks every drained write.
  task automatic sb_cycle(input string nm, input logic v, input int a, input int d,
                          input logic dr, input int exp_cnt);
    logic [A+W-1:0] exp_w;
    drive(1'b1, v, a, d, dr, 0);
    @(negedge Clk);
    chk({nm, " count"}, 32'(Count), 32'(exp_cnt));
    if (WriteEn) begin
      if (sb_q.size() == 0) begin
        chk({nm, " unexpected write"}, 32'(WriteEn), 32'(0));
      end else begin
        exp_w = sb_q.pop_front();
        chk({nm, " write addr/data"}, 32'({Waddr, DataIn}), 32'(exp_w));
      end
    end
    if (v && InReady) sb_q.push_back({A'(a), W'(d)});
    $display("cycle %s: v=%0b dr=%0b we=%0b waddr=%0d data=%02h count=%0d",
             nm, v, dr, WriteEn, Waddr, DataIn, Count);
    finish_cycle();
  endtask

  initial begin
    drive(1'b0, 1'b0, 0, 0, 1'b0, 0);
    finish_cycle();

    // Reset held with traffic offered: nothing accepted or written.
    addv(0, 1, 1, 'hFF, 1, 1,   0, 0, 0, 0,     0, 0,     0);
    addv(0, 1, 1, 'hFF, 1, 1,   0, 0, 0, 0,     0, 0,     0);
    // Single push drains the next cycle; offered entry never looks itself up.
    addv(1, 1, 3, 'h5A, 1, 3,   1, 0, 0, 0,     0, 0,     0);
    addv(1, 0, 0, 0,    1, 3,   1, 1, 3, 'h5A,  1, 'h5A,  1);
    addv(1, 0, 0, 0,    1, 3,   1, 0, 0, 0,     0, 0,     0);
    // Fill to full with drain stalled, then drain in order with wrap-around.
    addv(1, 1, 1, 'hA1, 0, 0,   1, 0, 0, 0,     0, 0,     0);
    addv(1, 1, 2, 'hA2, 0, 2,   1, 0, 1, 'hA1,  0, 0,     1);
    addv(1, 1, 3, 'hA3, 0, 1,   1, 0, 1, 'hA1,  1, 'hA1,  2);
    addv(1, 1, 4, 'hA4, 0, 3,   1, 0, 1, 'hA1,  1, 'hA3,  3);
    addv(1, 1, 5, 'hA5, 0, 4,   0, 0, 1, 'hA1,  1, 'hA4,  4);
    addv(1, 1, 5, 'hA5, 1, 1,   0, 1, 1, 'hA1,  1, 'hA1,  4);
    addv(1, 1, 5, 'hA5, 1, 5,   1, 1, 2, 'hA2,  0, 0,     3);
    addv(1, 0, 0, 0,    1, 5,   1, 1, 3, 'hA3,  1, 'hA5,  3);
    addv(1, 0, 0, 0,    1, 5,   1, 1, 4, 'hA4,  1, 'hA5,  2);
    addv(1, 0, 0, 0,    1, 2,   1, 1, 5, 'hA5,  0, 0,     1);
    addv(1, 0, 0, 0,    1, 5,   1, 0, 0, 0,     0, 0,     0);
    // Duplicate addresses: youngest resident match wins, popped head still hits.
    addv(1, 1, 2, 'h11, 0, 2,   1, 0, 0, 0,     0, 0,     0);
    addv(1, 1, 5, 'h22, 0, 2,   1, 0, 2, 'h11,  1, 'h11,  1);
    addv(1, 1, 2, 'h33, 0, 2,   1, 0, 2, 'h11,  1, 'h11,  2);
    addv(1, 0, 0, 0,    0, 2,   1, 0, 2, 'h11,  1, 'h33,  3);
    addv(1, 0, 0, 0,    0, 5,   1, 0, 2, 'h11,  1, 'h22,  3);
    addv(1, 0, 0, 0,    0, 7,   1, 0, 2, 'h11,  0, 0,     3);
    addv(1, 0, 0, 0,    1, 2,   1, 1, 2, 'h11,  1, 'h33,  3);
    addv(1, 0, 0, 0,    1, 5,   1, 1, 5, 'h22,  1, 'h22,  2);
    addv(1, 0, 0, 0,    1, 2,   1, 1, 2, 'h33,  1, 'h33,  1);
    addv(1, 0, 0, 0,    1, 2,   1, 0, 0, 0,     0, 0,     0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].dr, vecs[i].la);
      @(negedge Clk);
      chk($sformatf("row%0d InReady", i), 32'(InReady), 32'(vecs[i].e_rdy));
      chk($sformatf("row%0d WriteEn", i), 32'(WriteEn), 32'(vecs[i].e_we));
      chk($sformatf("row%0d Waddr", i), 32'(Waddr), 32'(vecs[i].e_wa));
      chk($sformatf("row%0d DataIn", i), 32'(DataIn), 32'(vecs[i].e_wd));
      chk($sformatf("row%0d LookupHit", i), 32'(LookupHit), 32'(vecs[i].e_hit));
      chk($sformatf("row%0d LookupData", i), 32'(LookupData), 32'(vecs[i].e_ld));
      chk($sformatf("row%0d Count", i), 32'(Count), 32'(vecs[i].e_cnt));
      chk($sformatf("row%0d Full", i), 32'(Full), 32'(vecs[i].e_cnt == D));
      chk($sformatf("row%0d Empty", i), 32'(Empty), 32'(vecs[i].e_cnt == 0));
      $display("row %0d: rst=%0b v=%0b dr=%0b rdy=%0b we=%0b waddr=%0d data=%02h hit=%0b ldata=%02h count=%0d",
               i, vecs[i].rst, vecs[i].v, vecs[i].dr, InReady, WriteEn, Waddr, DataIn,
               LookupHit, LookupData, Count);
      finish_cycle();
    end

    // Simultaneous push and pop for three cycles keeps Count at 2 and preserves order.
    sb_q.delete();
    sb_cycle("s5 fill0", 1'b1, 1, 'hB1, 1'b0, 0);
    sb_cycle("s5 fill1", 1'b1, 2, 'hB2, 1'b0, 1);
    sb_cycle("s5 pp0",   1'b1, 3, 'hB3, 1'b1, 2);
    sb_cycle("s5 pp1",   1'b1, 4, 'hB4, 1'b1, 2);
    sb_cycle("s5 pp2",   1'b1, 5, 'hB5, 1'b1, 2);
    begin
      int budget = 8;
      while (Count != 0 && budget > 0) begin
        sb_cycle("s5 drain", 1'b0, 0, 0, 1'b1, int'(Count));
        budget--;
      end
      chk("s5 drained within budget", 32'(Count), 32'(0));
      chk("s5 scoreboard empty", 32'(sb_q.size()), 32'(0));
    end

    // Reset after the first pop discards the remaining entries.
    sb_cycle("s6 fill0", 1'b1, 6, 'hC6, 1'b0, 0);
    sb_cycle("s6 fill1", 1'b1, 7, 'hC7, 1'b0, 1);
    sb_cycle("s6 fill2", 1'b1, 1, 'hC1, 1'b0, 2);
    sb_cycle("s6 pop",   1'b0, 0, 0,    1'b1, 3);
    drive(1'b0, 1'b1, 2, 'hEE, 1'b1, 7);
    @(negedge Clk);
    chk("s6 rst WriteEn", 32'(WriteEn), 32'(0));
    chk("s6 rst InReady", 32'(InReady), 32'(0));
    $display("cycle s6 reset: we=%0b rdy=%0b count=%0d", WriteEn, InReady, Count);
    finish_cycle();
    sb_q.delete();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 0, 0, 1'b1, 7);
      @(negedge Clk);
      chk($sformatf("s6 post%0d WriteEn", c), 32'(WriteEn), 32'(0));
      chk($sformatf("s6 post%0d Count", c), 32'(Count), 32'(0));
      chk($sformatf("s6 post%0d Empty", c), 32'(Empty), 32'(1));
      chk($sformatf("s6 post%0d Waddr", c), 32'(Waddr), 32'(0));
      chk($sformatf("s6 post%0d LookupHit", c), 32'(LookupHit), 32'(0));
      $display("cycle s6 post%0d: we=%0b count=%0d empty=%0b", c, WriteEn, Count, Empty);
      finish_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
